// File: rtl/aes_128_pkg.sv
// aes_128_pkg: shared types, constants and helpers for the AES-128 key schedule
package aes_128_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {EMPTY, LOADED, READY, W1, W2, W3} key_state_t;
  localparam logic [7:0] RCON_INIT = 8'h01;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_128_key_expand_4clk_if.sv
// aes_128_key_expand_4clk_if: control request / round-key bus between control and key schedule
interface aes_128_key_expand_4clk_if;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic [3:0]   round_num;
  logic         busy;
  logic         done;
  logic         seq_err;
  modport master (output start, key_in, key_ready,
                  input  round_key, round_key_valid, round_num, busy, done, seq_err);
  modport slave  (input  start, key_in, key_ready,
                  output round_key, round_key_valid, round_num, busy, done, seq_err);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational FIPS-197 forward S-box lookup
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/aes_128_key_expand_4clk.sv
// aes_128_key_expand_4clk: word-serial AES-128 key schedule, one round key per 4 clocks
module aes_128_key_expand_4clk
  import aes_128_pkg::*;
#(
  parameter int NR = 10
) (
  input logic clk,
  input logic kill,
  aes_128_key_expand_4clk_if.slave bus
);
  if (NR != 10) begin : g_nr_chk
    $error("aes_128_key_expand_4clk: NR must be 10 for AES-128");
  end
  key_state_t state;
  word_t w [4];
  word_t rot;
  word_t sub;
  logic [7:0] rcon;
  assign rot = rot_word(w[3]);
  assign bus.round_key = {w[0], w[1], w[2], w[3]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.in_byte(rot[8*i +: 8]), .out_byte(sub[8*i +: 8]));
  end
  // Each word is updated in place so the register always holds the in-progress round key.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state               <= EMPTY;
      w                   <= '{default: '0};
      rcon                <= RCON_INIT;
      bus.round_key_valid <= 1'b0;
      bus.round_num       <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.seq_err         <= 1'b0;
    end else begin
      bus.round_key_valid <= 1'b0;
      bus.seq_err         <= 1'b0;
      if (bus.start) begin
        w             <= '{bus.key_in[127:96], bus.key_in[95:64], bus.key_in[63:32], bus.key_in[31:0]};
        rcon          <= RCON_INIT;
        bus.round_num <= '0;
        bus.busy      <= 1'b0;
        bus.done      <= 1'b0;
        state         <= LOADED;
      end else begin
        case (state)
          EMPTY: bus.seq_err <= bus.key_ready;
          LOADED: if (bus.key_ready) begin
            bus.round_key_valid <= 1'b1;
            state               <= READY;
          end
          READY: if (bus.key_ready) begin
            if (bus.round_num == 4'(NR)) bus.seq_err <= 1'b1;
            else begin
              w[0]     <= w[0] ^ sub ^ {rcon, 24'h0};
              bus.busy <= 1'b1;
              state    <= W1;
            end
          end
          W1: begin
            w[1]        <= w[1] ^ w[0];
            bus.seq_err <= bus.key_ready;
            state       <= W2;
          end
          W2: begin
            w[2]        <= w[2] ^ w[1];
            bus.seq_err <= bus.key_ready;
            state       <= W3;
          end
          W3: begin
            w[3]                <= w[3] ^ w[2];
            bus.seq_err         <= bus.key_ready;
            bus.round_num       <= bus.round_num + 4'd1;
            bus.round_key_valid <= 1'b1;
            bus.busy            <= 1'b0;
            bus.done            <= bus.round_num == 4'(NR - 1);
            rcon                <= xtime(rcon);
            state               <= READY;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_128_key_expand_4clk.sv
// tb_aes_128_key_expand_4clk: random and directed stimulus against a FIPS-197 key-expansion model
module tb_aes_128_key_expand_4clk;
  localparam int MAXC = 4096;
  localparam logic [127:0] FK = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  logic clk = 1'b0;
  logic kill = 1'b1;
  aes_128_key_expand_4clk_if bus();
  aes_128_key_expand_4clk #(.NR(10)) dut (.clk(clk), .kill(kill), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] sb [256];
  logic [127:0] ks [11];
  bit ev [MAXC];
  bit eerr [MAXC];
  bit ebusy [MAXC];
  int ern [MAXC];
  int edone [MAXC];
  logic [127:0] ekey [MAXC];
  bit loaded = 1'b0;
  int nxt = 0;
  int busy_end = -1;
  int cur_rn = 0;
  bit cur_done = 1'b0;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", n, cyc, a, e);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inverse plus affine map, independent of any lookup table.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      ev[i] = 1'b0;
      eerr[i] = 1'b0;
      ebusy[i] = 1'b0;
      ern[i] = -1;
      edone[i] = -1;
    end
  endtask

  // Drives one cycle of inputs and records what the schedule must show in later cycles.
  task automatic step(input bit s, input logic [127:0] k, input bit kr);
    @(posedge clk);
    #1;
    bus.start = s;
    bus.key_in = k;
    bus.key_ready = kr;
    if (s) begin
      expand(k);
      loaded = 1'b1;
      nxt = 0;
      busy_end = -1;
      clear_from(cyc + 1);
      ern[cyc+1] = 0;
      edone[cyc+1] = 0;
    end else if (kr) begin
      if (!loaded || cyc <= busy_end || nxt == 11) eerr[cyc+1] = 1'b1;
      else if (nxt == 0) begin
        ev[cyc+1] = 1'b1;
        ekey[cyc+1] = ks[0];
        ern[cyc+1] = 0;
        nxt = 1;
      end else begin
        ev[cyc+4] = 1'b1;
        ekey[cyc+4] = ks[nxt];
        ern[cyc+4] = nxt;
        for (int i = 1; i < 4; i++) ebusy[cyc+i] = 1'b1;
        busy_end = cyc + 3;
        if (nxt == 10) edone[cyc+4] = 1;
        nxt++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (kill) begin
      cur_rn = 0;
      cur_done = 1'b0;
    end else begin
      if (ern[cyc] >= 0) cur_rn = ern[cyc];
      if (edone[cyc] >= 0) cur_done = edone[cyc][0];
    end
    chk("valid", bus.round_key_valid, ev[cyc]);
    chk("seq_err", bus.seq_err, eerr[cyc]);
    chk("busy", bus.busy, ebusy[cyc]);
    chk("done", bus.done, cur_done);
    chk("round_num", bus.round_num, cur_rn);
    if (ev[cyc]) chk("round_key", bus.round_key, ekey[cyc]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rk;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.key_ready = 1'b0;
    clear_from(0);
    build_sbox();
    chk("sbox_00", sb[0], 8'h63);
    chk("sbox_53", sb[8'h53], 8'hed);
    repeat (3) @(posedge clk);
    #3 kill = 1'b0;
    step(1'b0, '0, 1'b1);
    idle(2);
    step(1'b1, FK, 1'b0);
    chk("model_k0", ks[0], FK);
    chk("model_k1", ks[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("model_k10", ks[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    step(1'b0, '0, 1'b1);
    idle(3);
    repeat (10) begin
      step(1'b0, '0, 1'b1);
      idle(3);
    end
    step(1'b0, '0, 1'b1);
    idle(3);
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b1, rk, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(4);
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b1, rk, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(1);
    step(1'b1, '0, 1'b0);
    chk("model_z0", ks[0], 128'h0);
    chk("model_z1", ks[1], 128'h62636363_62636363_62636363_62636363);
    step(1'b0, '0, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(5);
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b1, rk, 1'b0);
    step(1'b0, '0, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(1);
    #2 kill = 1'b1;
    clear_from(cyc);
    loaded = 1'b0;
    nxt = 0;
    busy_end = -1;
    #1;
    chk("kill_busy", bus.busy, 1'b0);
    chk("kill_valid", bus.round_key_valid, 1'b0);
    chk("kill_key", bus.round_key, 128'h0);
    chk("kill_rn", bus.round_num, 4'd0);
    @(posedge clk);
    #3 kill = 1'b0;
    step(1'b0, '0, 1'b1);
    idle(2);
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b1, rk, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b1);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      bit s;
      bit kr;
      s = ($urandom_range(0, 29) == 0) || (!loaded && $urandom_range(0, 4) == 0);
      kr = $urandom_range(0, 2) == 0;
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(s, rk, kr);
    end
    idle(6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_128_key_expand_4clk.md
Name: aes_128_key_expand_4clk

Overview:
- Word-serial AES-128 key schedule that sits directly downstream of the 4-clock-per-round AES control block.
- Loads the cipher key on `start` and produces one round key per `key_ready` pulse.
- Round key 0 is the raw key. Round keys 1..10 are each computed one 32-bit word per clock over 4 clocks, which matches the 4-clock round cadence.
- Feeds the AddRoundKey stage of the datapath.

Parameters:
- NR, 10, number of expansion rounds (fixed for AES-128; checked by an elaboration assertion).

Ports:
- clk  in  1  system clock
- kill  in  1  asynchronous active-high reset
- start  in  1  from control; loads key_in and aborts any calculation in progress
- key_in  in  128  cipher key, big-endian (w0 = key_in[127:96]); sampled only on start
- key_ready  in  1  from control; one-cycle request for the next round key
- round_key  out  128  current round key {w0,w1,w2,w3}; valid only while round_key_valid=1
- round_key_valid  out  1  one-cycle pulse: round_key holds key number round_num
- round_num  out  4  index 0..10 of the key last presented
- busy  out  1  high while in states W1..W3
- done  out  1  high from round 10 valid until the next start
- seq_err  out  1  one-cycle pulse for an illegal key_ready

Behaviour:
- Reset: kill is asynchronous and active-high; the clock is clk.
  - On kill, all outputs go to 0, state=EMPTY, rcon=8'h01.
  - kill mid-calculation discards everything.
- States: EMPTY, LOADED, READY, W1, W2, W3.
- start (any state):
  - round_key<=key_in, rcon<=8'h01, round_num<=0, state<=LOADED, done<=0.
  - start has priority over a same-cycle key_ready; that key_ready is dropped and seq_err is not raised.
- LOADED + key_ready:
  - round_key_valid=1 next cycle, round_num=0, state<=READY; no computation.
- READY + key_ready with round_num<10: the edge ending cycle t writes
  - w0 <= w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0};
  - state<=W1, busy=1 from t+1.
- W1 edge: w1<=w1^w0. W2 edge: w2<=w2^w1. W3 edge: w3<=w3^w2, state<=READY.
  - At the W3 edge also: round_num<=round_num+1 and rcon<=xtime(rcon) (xtime reduces by 8'h1B on MSB overflow).
  - rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
- Timing:
  - round_key_valid is high in cycle t+4.
  - A key_ready in cycle t+4 (back-to-back at the 4-clock cadence) is accepted in that same cycle.
  - round_key is therefore guaranteed stable only in the valid cycle; intermediate words change cycle by cycle.
- done is set together with the valid pulse for round_num=10.
- seq_err pulses one cycle, and key_ready is otherwise ignored, when key_ready arrives in any of:
  - W1, W2 or W3;
  - EMPTY;
  - READY with round_num=10.
- SubWord uses 4 instances of a combinational S-box on RotWord(w3) = {w3[23:0],w3[31:24]}.
- No wrap-around: after round 10 only start restarts the schedule.

Decomposition:
- Package aes_128_pkg holds:
  - typedef word_t (logic[31:0]);
  - enum key_state_t for the states above;
  - constant RCON_INIT=8'h01;
  - function xtime; function rot_word.
- Sub-module aes_sbox: 8-bit in, 8-bit out combinational FIPS-197 S-box table, instantiated 4 times. It is reusable by SubBytes.

Test Plan:
- FIPS-197 A.1: key_in=2b7e1516_28aed2a6_abf71588_09cf4f3c, then start, then key_ready at cycles +1,+5,+9,...
  - Valid with round_num=0 returns the key itself.
  - round 1 = a0fafe17_88542cb1_23a33939_2a6c7605.
  - round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, with done=1.
- Latency: a key_ready in READY gives round_key_valid exactly 4 cycles later and busy=1 for 3 cycles.
  - A back-to-back key_ready in the valid cycle is accepted with no seq_err.
- Illegal requests:
  - key_ready during W2 gives seq_err=1 for one cycle and round_num unchanged.
  - An 11th post-load key_ready after round 10 gives seq_err and no valid.
- Abort: start during W2 with a new key = all-zero key, then key_ready ×2.
  - Round 0 = 0.
  - Round 1 = 62636363_62636363_62636363_62636363.
- Reset: assert kill asynchronously (between clock edges) mid-W1.
  - All outputs go to 0 immediately.
  - After release, key_ready gives seq_err (state EMPTY).
- start and key_ready in the same cycle: load occurs, no valid, no seq_err.
  - A subsequent key_ready gives round_num=0.
